vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Sits directly downstream of the VGA timing generator.
- Consumes hsync/vsync and the signed-offset pixel coordinates xpos/ypos.
- Reads a double-buffered 160x120 RGB332 framebuffer at 4x scale and drives the VGA pins with sync delayed to stay aligned with colour.
- Provides a frame-boundary buffer-swap handshake to the drawing logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- SCALE_SHIFT, 2, log2 of the pixel replication factor
- FB_W, 160, framebuffer width in words (H_ACTIVE>>SCALE_SHIFT)
- FB_WORDS, 19200, words per buffer (FB_W*(V_ACTIVE>>SCALE_SHIFT))
- RD_LAT, 1, framebuffer RAM read latency in cycles (1..3)
- ADDR_W, 16, framebuffer address width (must hold 2*FB_WORDS)

Ports:
- VGA_clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hsync_in  in  1  horizontal sync from the timing generator
- vsync_in  in  1  vertical sync from the timing generator
- xpos  in  10  pixel column; values >= H_ACTIVE (including wrapped negatives) mean blank
- ypos  in  10  pixel row; values >= V_ACTIVE mean blank
- fb_addr  out  ADDR_W  framebuffer read address
- fb_rdata  in  8  RGB332 read data, valid RD_LAT cycles after fb_addr
- swap_req  in  1  single-cycle request to flip the displayed buffer
- swap_ack  out  1  single-cycle pulse when the flip has taken effect
- disp_buf  out  1  index of the buffer currently displayed
- hsync  out  1  delayed hsync to the pins
- vsync  out  1  delayed vsync to the pins
- vga_r, vga_g, vga_b  out  4 each  colour to the DAC
- frame_start  out  1  pulse aligned with output pixel (0,0)

Behaviour:
- Reset is asynchronous and active-low; the pipeline has a single clock, VGA_clk.
- Reset values: all outputs 0; disp_buf=0; swap FSM in IDLE; all pipeline registers 0.
- Stage S0, registered:
  - active = (xpos < H_ACTIVE) && (ypos < V_ACTIVE), using unsigned compares.
  - fb_addr = disp_buf*FB_WORDS + (ypos>>SCALE_SHIFT)*FB_W + (xpos>>SCALE_SHIFT).
  - When not active, fb_addr = 0.
  - Arithmetic is done in ADDR_W bits with no overflow for legal inputs.
- Delay stages: active, hsync, vsync and first-pixel flags are delayed RD_LAT cycles to match fb_rdata.
- Output stage, registered:
  - When active: vga_r = {R[2:0],R[2]}, vga_g = {G[2:0],G[2]}, vga_b = {B[1:0],B[1:0]}.
  - When not active: all colour outputs = 0.
- Latency: every output (hsync, vsync, colour, frame_start) lags its input by exactly RD_LAT+2 cycles. fb_addr lags by 1 cycle.
- frame_start: asserted when the delayed input had xpos==0 && ypos==0.
- Swap FSM (IDLE, PENDING):
  - Frame-end event = xpos==0 && ypos==V_ACTIVE at the input.
  - IDLE: swap_req=1 -> PENDING. This holds even if the frame-end event occurs in the same cycle; the flip then happens at the next frame end.
  - PENDING: additional swap_req pulses are merged (ignored). On the frame-end event, toggle disp_buf, pulse swap_ack for 1 cycle, go to IDLE.
  - disp_buf therefore changes only during vertical blank; the next visible frame reads entirely from the new buffer.
- Reset mid-frame: the pipeline clears immediately and a pending swap is lost (no ack). Output stays blank until fresh coordinates propagate through the pipeline.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE, V_ACTIVE, SCALE_SHIFT, FB_W, FB_WORDS
  - the swap FSM state encoding
  - the RGB332->444 expansion function
- Sub-module fb_swap_ctrl holds the swap FSM plus the disp_buf register. The top level contains the address stage, delay line and colour stage.

Test Plan:
- Reset and RD_LAT=1:
  - hold rst_n=0 -> all outputs 0.
  - release with xpos=0, ypos=0, fb_rdata=8'hE0 -> vga_r=4'hF, vga_g=0, vga_b=0 and frame_start=1, both exactly 3 cycles after the coordinate.
- Address mapping, disp_buf=0:
  - xpos=5, ypos=9 -> fb_addr=321 one cycle later.
  - xpos=639, ypos=479 -> fb_addr=19199.
- Blanking:
  - xpos=640, ypos=10, fb_rdata=8'hFF -> colour 0.
  - xpos=10'h3F0 (wrapped negative), ypos=0 -> colour 0 and fb_addr=0.
- Sync alignment: hsync_in pulse of 96 cycles -> identical-width hsync pulse delayed RD_LAT+2 cycles; repeat with RD_LAT=3.
- Swap handshake:
  - swap_req pulse at ypos=100, second pulse at ypos=200 -> exactly one swap_ack at xpos=0, ypos=480; disp_buf=1.
  - next frame, address of pixel (0,0) = 19200.
- Coincident and reset cases:
  - swap_req on the same cycle as the frame-end event -> no ack this frame; ack at the following frame end.
  - rst_n pulsed while PENDING -> no ack; disp_buf=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, swap FSM encoding and colour expansion for the VGA
// pixel fetch path (160x120 RGB332 framebuffer shown at 4x on 640x480).
package vga_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int SCALE_SHIFT = 2;
  localparam int FB_W        = H_ACTIVE >> SCALE_SHIFT;
  localparam int FB_WORDS    = FB_W * (V_ACTIVE >> SCALE_SHIFT);

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
    logic first;
  } pix_flags_t;

  // MSB replication keeps full-scale RGB332 values at full-scale 4-bit DAC codes
  function automatic logic [11:0] rgb332_to_444(input logic [7:0] pix);
    return {pix[7:5], pix[7], pix[4:2], pix[4], pix[1:0], pix[1:0]};
  endfunction

endpackage

// File: rtl/fb_swap_ctrl.sv
// Double-buffer swap handshake: latches a request and flips the displayed
// buffer at the next frame-end event (start of vertical blank).
module fb_swap_ctrl
  import vga_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic swap_req_i,
  input  logic frame_end_i,
  output logic swap_ack_o,
  output logic disp_buf_o
);

  swap_state_e state_q;
  logic        disp_buf_q;
  logic        swap_ack_q;

  // Swap FSM with registered ack and buffer index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= SWAP_IDLE;
      disp_buf_q <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= 1'b0;
      case (state_q)
        SWAP_IDLE: begin
          if (swap_req_i) begin
            state_q <= SWAP_PENDING;
          end
        end
        SWAP_PENDING: begin
          if (frame_end_i) begin
            state_q    <= SWAP_IDLE;
            disp_buf_q <= ~disp_buf_q;
            swap_ack_q <= 1'b1;
          end
        end
        default: begin
          state_q <= SWAP_IDLE;
        end
      endcase
    end
  end

  assign swap_ack_o = swap_ack_q;
  assign disp_buf_o = disp_buf_q;

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer fetch and colour stage: maps screen coordinates to framebuffer
// addresses and re-aligns sync with the returning pixel data.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 16
) (
  input  logic              VGA_clk,
  input  logic              rst_n,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [9:0]        xpos,
  input  logic [9:0]        ypos,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_rdata,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              disp_buf,
  output logic              hsync,
  output logic              vsync,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              frame_start
);

  localparam int         LAST  = RD_LAT - 1;
  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  logic              disp_buf_s;
  logic              frame_end_s;
  logic              active_s;
  logic [ADDR_W-1:0] base_s;
  logic [ADDR_W-1:0] row_s;
  logic [ADDR_W-1:0] col_s;
  logic [ADDR_W-1:0] addr_d;
  pix_flags_t        flags_d;

  logic [ADDR_W-1:0] addr_q;
  pix_flags_t        s0_q;
  pix_flags_t        dly_q [RD_LAT];
  logic [11:0]       rgb_q;
  logic              hsync_q;
  logic              vsync_q;
  logic              frame_start_q;

  fb_swap_ctrl u_swap (
    .clk_i       (VGA_clk),
    .rst_ni      (rst_n),
    .swap_req_i  (swap_req),
    .frame_end_i (frame_end_s),
    .swap_ack_o  (swap_ack),
    .disp_buf_o  (disp_buf_s)
  );

  // Unsigned compares make wrapped negative coordinates fall into blanking
  always_comb begin
    active_s    = (xpos < H_LIM) && (ypos < V_LIM);
    frame_end_s = (xpos == 10'd0) && (ypos == V_LIM);
    if (disp_buf_s) begin
      base_s = ADDR_W'(FB_WORDS);
    end else begin
      base_s = '0;
    end
    row_s = ADDR_W'(ypos >> SCALE_SHIFT) * ADDR_W'(FB_W);
    col_s = ADDR_W'(xpos >> SCALE_SHIFT);
    if (active_s) begin
      addr_d = base_s + row_s + col_s;
    end else begin
      addr_d = '0;
    end
    flags_d.active = active_s;
    flags_d.hsync  = hsync_in;
    flags_d.vsync  = vsync_in;
    flags_d.first  = (xpos == 10'd0) && (ypos == 10'd0);
  end

  // Address stage plus RD_LAT-deep flag delay matching the RAM latency
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      s0_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      addr_q   <= addr_d;
      s0_q     <= flags_d;
      dly_q[0] <= s0_q;
      for (int i = 1; i < RD_LAT; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Output stage: colour expansion and sync re-timing
  always_ff @(posedge VGA_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= dly_q[LAST].hsync;
      vsync_q       <= dly_q[LAST].vsync;
      frame_start_q <= dly_q[LAST].first;
      if (dly_q[LAST].active) begin
        rgb_q <= rgb332_to_444(fb_rdata);
      end else begin
        rgb_q <= 12'h000;
      end
    end
  end

  assign fb_addr     = addr_q;
  assign disp_buf    = disp_buf_s;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign vga_r       = rgb_q[11:8];
  assign vga_g       = rgb_q[7:4];
  assign vga_b       = rgb_q[3:0];
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: two instances (read latency 1 and 3) share the
// same stimulus and are checked every cycle against a cycle-history model.
module tb_vga_pixel_fetch;

  localparam int AW   = 16;
  localparam int HIST = 4096;
  localparam int MEMN = 38400;

  typedef struct packed {
    bit       v;
    bit [9:0] x;
    bit [9:0] y;
    bit       hs;
    bit       vs;
    bit       b;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n, hsync_in, vsync_in, swap_req;
  logic [9:0]    xpos, ypos;
  logic [AW-1:0] a1, a3;
  logic [7:0]    rd1, rd3;
  logic          ack1, ack3, buf1, buf3, hs1, hs3, vs1, vs3, fs1, fs3;
  logic [3:0]    r1, g1, b1, r3, g3, b3;

  logic [7:0] mem [MEMN];
  logic [7:0] p1;
  logic [7:0] p3 [3];
  ent_t       hist [HIST];

  int  n_assert = 0, n_fail = 0, cyc = 0;
  int  hs_cnt1, hs_cnt3, ack_cnt;
  bit  m_pend = 1'b0, m_buf = 1'b0, m_ack = 1'b0;

  always #5 clk = ~clk;

  vga_pixel_fetch #(.RD_LAT(1), .ADDR_W(AW)) dut1 (
    .VGA_clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .xpos(xpos), .ypos(ypos), .fb_addr(a1), .fb_rdata(rd1),
    .swap_req(swap_req), .swap_ack(ack1), .disp_buf(buf1),
    .hsync(hs1), .vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  vga_pixel_fetch #(.RD_LAT(3), .ADDR_W(AW)) dut3 (
    .VGA_clk(clk), .rst_n(rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .xpos(xpos), .ypos(ypos), .fb_addr(a3), .fb_rdata(rd3),
    .swap_req(swap_req), .swap_ack(ack3), .disp_buf(buf3),
    .hsync(hs3), .vsync(vs3), .vga_r(r3), .vga_g(g3), .vga_b(b3), .frame_start(fs3)
  );

  // Framebuffer RAM models with 1 and 3 cycle read latency
  always @(posedge clk) begin
    p1    <= mem[a1];
    p3[0] <= mem[a3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rd1 = p1;
  assign rd3 = p3[2];

  function automatic ent_t get(int idx);
    ent_t z = '0;
    if (idx < 0) return z;
    return hist[idx % HIST];
  endfunction

  function automatic bit is_act(ent_t e);
    return e.v && (e.x < 640) && (e.y < 480);
  endfunction

  function automatic int exp_addr(ent_t e);
    if (!is_act(e)) return 0;
    return int'(e.b) * 19200 + (int'(e.y) / 4) * 160 + int'(e.x) / 4;
  endfunction

  function automatic logic [11:0] exp_rgb(ent_t e);
    logic [7:0] p;
    int r, g, b;
    if (!is_act(e)) return 12'h000;
    p = mem[exp_addr(e)];
    r = int'(p[7:5]) * 2 + int'(p[7:5]) / 4;
    g = int'(p[4:2]) * 2 + int'(p[4:2]) / 4;
    b = int'(p[1:0]) * 5;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_dut(input string nm, input int lat, input logic [AW-1:0] addr,
                           input logic hs, input logic vs, input logic fs,
                           input logic [11:0] rgb, input logic ack, input logic bf);
    ent_t ea, eo;
    ea = get(cyc - 1);
    eo = get(cyc - lat - 2);
    chk({nm, ".fb_addr"}, 32'(addr), exp_addr(ea));
    chk({nm, ".hsync"}, 32'(hs), 32'(eo.v && eo.hs));
    chk({nm, ".vsync"}, 32'(vs), 32'(eo.v && eo.vs));
    chk({nm, ".frame_start"}, 32'(fs), 32'(eo.v && eo.x == 0 && eo.y == 0));
    chk({nm, ".rgb"}, 32'(rgb), 32'(exp_rgb(eo)));
    chk({nm, ".swap_ack"}, 32'(ack), 32'(m_ack));
    chk({nm, ".disp_buf"}, 32'(bf), 32'(m_buf));
  endtask

  task automatic check_all();
    check_dut("d1", 1, a1, hs1, vs1, fs1, {r1, g1, b1}, ack1, buf1);
    check_dut("d3", 3, a3, hs3, vs3, fs3, {r3, g3, b3}, ack3, buf3);
  endtask

  task automatic tick();
    ent_t e;
    e.v = rst_n; e.x = xpos; e.y = ypos; e.hs = hsync_in; e.vs = vsync_in; e.b = m_buf;
    hist[cyc % HIST] = e;
    if (rst_n) begin
      m_ack = 1'b0;
      if (!m_pend) begin
        if (swap_req) m_pend = 1'b1;
      end else if (xpos == 0 && ypos == 480) begin
        m_buf  = ~m_buf;
        m_ack  = 1'b1;
        m_pend = 1'b0;
      end
    end else begin
      m_ack = 1'b0; m_pend = 1'b0; m_buf = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    if (hs1)  hs_cnt1++;
    if (hs3)  hs_cnt3++;
    if (ack1) ack_cnt++;
  endtask

  task automatic set_xy(input int x, input int y);
    xpos = 10'(x);
    ypos = 10'(y);
  endtask

  task automatic rand_active();
    set_xy($urandom_range(639, 0), $urandom_range(479, 0));
  endtask

  initial begin
    for (int i = 0; i < MEMN; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hE0;
    for (int i = 0; i < HIST; i++) hist[i] = '0;
    rst_n = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0; swap_req = 1'b0;
    set_xy(0, 0);

    // reset state
    #1;
    check_all();
    repeat (4) tick();

    // release on pixel (0,0): red appears three cycles later on d1
    rst_n = 1'b1;
    set_xy(0, 0);
    tick();
    set_xy(5, 9);
    tick();
    chk("addr_5_9", 32'(a1), 32'd321);
    set_xy(639, 479);
    tick();
    chk("addr_639_479", 32'(a1), 32'd19199);
    chk("red_r", 32'(r1), 32'h0000000F);
    chk("red_g", 32'(g1), 32'd0);
    chk("red_fs", 32'(fs1), 32'd1);

    // blanking, including a wrapped negative column
    set_xy(640, 10);
    tick();
    set_xy(10'h3F0, 0);
    tick();
    chk("addr_neg", 32'(a1), 32'd0);
    rand_active();
    tick();
    chk("blank_rgb", 32'({r1, g1, b1}), 32'd0);

    // 96-cycle hsync pulse over random active pixels
    hs_cnt1 = 0; hs_cnt3 = 0;
    hsync_in = 1'b1;
    for (int i = 0; i < 96; i++) begin rand_active(); tick(); end
    hsync_in = 1'b0;
    for (int i = 0; i < 8; i++) begin rand_active(); tick(); end
    chk("hs_width1", 32'(hs_cnt1), 32'd96);
    chk("hs_width3", 32'(hs_cnt3), 32'd96);

    // two requests in one frame merge into a single flip
    ack_cnt = 0;
    set_xy(20, 100); swap_req = 1'b1; tick(); swap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin rand_active(); tick(); end
    set_xy(20, 200); swap_req = 1'b1; tick(); swap_req = 1'b0;
    set_xy(0, 480); tick();
    chk("ack_frame_end", 32'(ack1), 32'd1);
    chk("buf_after_swap", 32'(buf1), 32'd1);
    for (int i = 0; i < 4; i++) begin set_xy(8 * i, 480); tick(); end
    chk("ack_once", 32'(ack_cnt), 32'd1);
    set_xy(0, 0); tick();
    chk("addr_buf1_origin", 32'(a1), 32'd19200);
    for (int i = 0; i < 6; i++) begin rand_active(); tick(); end

    // request coincident with frame end flips only at the following frame end
    ack_cnt = 0;
    set_xy(0, 480); swap_req = 1'b1; tick(); swap_req = 1'b0;
    chk("coinc_no_ack", 32'(ack1), 32'd0);
    for (int i = 0; i < 6; i++) begin rand_active(); tick(); end
    set_xy(0, 480); tick();
    chk("coinc_ack_next", 32'(ack1), 32'd1);
    chk("coinc_buf", 32'(buf1), 32'd0);
    chk("coinc_ack_cnt", 32'(ack_cnt), 32'd1);

    // flip back to buffer 1, then lose a pending request to reset
    set_xy(30, 30); swap_req = 1'b1; tick(); swap_req = 1'b0;
    set_xy(0, 480); tick();
    chk("pre_reset_buf", 32'(buf1), 32'd1);
    set_xy(40, 50); swap_req = 1'b1; tick(); swap_req = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < HIST; i++) hist[i] = '0;
    m_pend = 1'b0; m_buf = 1'b0; m_ack = 1'b0;
    #1;
    check_all();
    rand_active(); tick(); tick();
    rst_n = 1'b1;
    ack_cnt = 0;
    set_xy(0, 480); tick();
    for (int i = 0; i < 3; i++) begin rand_active(); tick(); end
    chk("reset_no_ack", 32'(ack_cnt), 32'd0);
    chk("reset_buf", 32'(buf1), 32'd0);

    // random coordinates, syncs and requests with occasional frame ends
    for (int i = 0; i < 400; i++) begin
      set_xy($urandom_range(1023, 0), $urandom_range(1023, 0));
      if ($urandom_range(15, 0) == 0) set_xy(0, 480);
      if ($urandom_range(31, 0) == 0) set_xy(0, 0);
      hsync_in = 1'($urandom_range(1, 0));
      vsync_in = 1'($urandom_range(1, 0));
      swap_req = ($urandom_range(11, 0) == 0);
      tick();
    end
    swap_req = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
